// File: rtl/sdram_burst_mover.sv
// Start/done copy engine: a burst read master fills a FWFT FIFO and a burst
// write master drains it into the destination window.
//
//   state   | meaning
//   R_IDLE  | no words left to request
//   R_WAIT  | words left, not enough FIFO room for the next burst yet
//   R_REQ   | read burst presented, waiting for acceptance
//   W_IDLE  | waiting for enough FIFO words to cover the next write burst
//   W_BURST | write burst in progress, one beat per accepted cycle
module sdram_burst_mover #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 24,
    parameter int BURST_LEN  = 8,
    parameter int BC_W       = 7,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic [3:0]        status,
    output logic [ADDR_W-1:0] rd_address,
    output logic              rd_read,
    output logic [BC_W-1:0]   rd_burstcount,
    input  logic              rd_waitrequest,
    input  logic [DATA_W-1:0] rd_readdata,
    input  logic              rd_readdatavalid,
    output logic [ADDR_W-1:0] wr_address,
    output logic              wr_write,
    output logic [BC_W-1:0]   wr_burstcount,
    output logic [DATA_W-1:0] wr_writedata,
    input  logic              wr_waitrequest
);

    localparam int BYTES = DATA_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} r_state_t;
    typedef enum logic       {W_IDLE, W_BURST}       w_state_t;

    r_state_t          r_state_q, r_state_d;
    w_state_t          w_state_q, w_state_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        bursts_q, bursts_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0]  words_left_rd_q, words_left_rd_d;
    logic [LEN_W-1:0]  words_left_wr_q, words_left_wr_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [BC_W-1:0]   rd_bc_q, rd_bc_d;
    logic [BC_W-1:0]   wr_bc_q, wr_bc_d;
    logic [BC_W-1:0]   wr_beat_q, wr_beat_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

    logic              start_edge;
    logic [BC_W-1:0]   rd_n;
    logic [BC_W-1:0]   wr_m;
    logic              rd_room;
    logic              rd_accept;
    logic              push;
    logic              pop;

    assign start_edge = start && !start_q && !busy_q;
    assign rd_n = (words_left_rd_q >= LEN_W'(BURST_LEN)) ? BC_W'(BURST_LEN) : BC_W'(words_left_rd_q);
    assign wr_m = (words_left_wr_q >= LEN_W'(BURST_LEN)) ? BC_W'(BURST_LEN) : BC_W'(words_left_wr_q);

    // Room counts words already requested but not yet returned, so the FIFO cannot overflow.
    assign rd_room = (SUM_W'(fifo_count_q) + SUM_W'(outstanding_q) + SUM_W'(rd_n))
                     <= SUM_W'(FIFO_DEPTH);

    assign rd_accept = (r_state_q == R_REQ) && !rd_waitrequest;
    // Data returned with nothing outstanding belongs to a transfer aborted by reset.
    assign push      = rd_readdatavalid && (outstanding_q != '0);
    assign pop       = (w_state_q == W_BURST) && !wr_waitrequest;

    always_comb begin
        r_state_d       = r_state_q;
        w_state_d       = w_state_q;
        start_d         = start;
        busy_d          = busy_q;
        done_d          = done_q;
        bursts_d        = bursts_q;
        rd_addr_d       = rd_addr_q;
        wr_addr_d       = wr_addr_q;
        words_left_rd_d = words_left_rd_q;
        words_left_wr_d = words_left_wr_q;
        rd_bc_d         = rd_bc_q;
        wr_bc_d         = wr_bc_q;
        wr_beat_d       = wr_beat_q;

        if (start_edge) begin
            bursts_d = '0;
            done_d   = 1'b0;
            if (len_words == '0) begin
                done_d = 1'b1;
            end else begin
                busy_d          = 1'b1;
                rd_addr_d       = src_addr;
                wr_addr_d       = dst_addr;
                words_left_rd_d = len_words;
                words_left_wr_d = len_words;
            end
        end

        case (r_state_q)
            R_IDLE, R_WAIT: begin
                if (words_left_rd_q != '0) begin
                    if (rd_room) begin
                        r_state_d = R_REQ;
                        rd_bc_d   = rd_n;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_REQ: begin
                if (!rd_waitrequest) begin
                    rd_addr_d       = rd_addr_q + ADDR_W'(rd_bc_q) * ADDR_W'(BYTES);
                    words_left_rd_d = words_left_rd_q - LEN_W'(rd_bc_q);
                    r_state_d       = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        case (w_state_q)
            W_IDLE: begin
                if ((words_left_wr_q != '0) && (fifo_count_q >= CNT_W'(wr_m))) begin
                    w_state_d = W_BURST;
                    wr_bc_d   = wr_m;
                    wr_beat_d = '0;
                end
            end
            W_BURST: begin
                if (!wr_waitrequest) begin
                    wr_beat_d = wr_beat_q + BC_W'(1);
                    if (wr_beat_q == wr_bc_q - BC_W'(1)) begin
                        wr_addr_d       = wr_addr_q + ADDR_W'(wr_bc_q) * ADDR_W'(BYTES);
                        words_left_wr_d = words_left_wr_q - LEN_W'(wr_bc_q);
                        bursts_d        = bursts_q + 4'd1;
                        w_state_d       = W_IDLE;
                        if (words_left_wr_q == LEN_W'(wr_bc_q)) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (rd_accept) outstanding_d = outstanding_d + CNT_W'(rd_bc_q);
        if (push)      outstanding_d = outstanding_d - CNT_W'(1);

        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push) fifo_count_d = fifo_count_d + CNT_W'(1);
        if (pop)  fifo_count_d = fifo_count_d - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q       <= R_IDLE;
            w_state_q       <= W_IDLE;
            start_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            bursts_q        <= '0;
            rd_addr_q       <= '0;
            wr_addr_q       <= '0;
            words_left_rd_q <= '0;
            words_left_wr_q <= '0;
            outstanding_q   <= '0;
            rd_bc_q         <= '0;
            wr_bc_q         <= '0;
            wr_beat_q       <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            fifo_count_q    <= '0;
        end else begin
            r_state_q       <= r_state_d;
            w_state_q       <= w_state_d;
            start_q         <= start_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            bursts_q        <= bursts_d;
            rd_addr_q       <= rd_addr_d;
            wr_addr_q       <= wr_addr_d;
            words_left_rd_q <= words_left_rd_d;
            words_left_wr_q <= words_left_wr_d;
            outstanding_q   <= outstanding_d;
            rd_bc_q         <= rd_bc_d;
            wr_bc_q         <= wr_bc_d;
            wr_beat_q       <= wr_beat_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fifo_count_q    <= fifo_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= rd_readdata;
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(push && !pop && (fifo_count_q == CNT_W'(FIFO_DEPTH))));
            assert (!(pop && (fifo_count_q == '0)));
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign status        = bursts_q;
    assign rd_read       = (r_state_q == R_REQ);
    assign rd_address    = rd_addr_q;
    assign rd_burstcount = rd_bc_q;
    assign wr_write      = (w_state_q == W_BURST);
    assign wr_address    = wr_addr_q;
    assign wr_burstcount = wr_bc_q;
    assign wr_writedata  = wr_write ? fifo_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_sdram_burst_mover.sv
// Directed bench for sdram_burst_mover: table of transfers against behavioural
// Avalon read/write slaves, plus zero-length and mid-transfer reset sequences.
module tb_sdram_burst_mover;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [23:0] len_words;
    logic        busy;
    logic        done;
    logic [3:0]  status;
    logic [31:0] rd_address;
    logic        rd_read;
    logic [6:0]  rd_burstcount;
    logic        rd_waitrequest;
    logic [15:0] rd_readdata;
    logic        rd_readdatavalid;
    logic [31:0] wr_address;
    logic        wr_write;
    logic [6:0]  wr_burstcount;
    logic [15:0] wr_writedata;
    logic        wr_waitrequest;

    sdram_burst_mover dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .len_words        (len_words),
        .busy             (busy),
        .done             (done),
        .status           (status),
        .rd_address       (rd_address),
        .rd_read          (rd_read),
        .rd_burstcount    (rd_burstcount),
        .rd_waitrequest   (rd_waitrequest),
        .rd_readdata      (rd_readdata),
        .rd_readdatavalid (rd_readdatavalid),
        .wr_address       (wr_address),
        .wr_write         (wr_write),
        .wr_burstcount    (wr_burstcount),
        .wr_writedata     (wr_writedata),
        .wr_waitrequest   (wr_waitrequest)
    );

    typedef struct {
        int          len;
        logic [31:0] src;
        logic [31:0] dst;
        int          rd_pct;
        int          wr_pct;
        int          gap_pct;
        int          restart_at;
        int          hold_cyc;
        int          budget;
        int          exp_bursts;
        logic [3:0]  exp_status;
        logic [31:0] exp_last_wr;
        int          exp_last_bc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          bc;
    } burst_t;

    vec_t        vecs [9];
    burst_t      rd_log [$];
    burst_t      wr_log [$];
    logic [31:0] rd_beat_q [$];
    logic [15:0] dst_mem [bit [31:0]];

    int checks = 0;
    int errors = 0;

    int   rd_wait_pct = 0;
    int   wr_wait_pct = 0;
    int   gap_pct     = 0;
    logic wr_hold     = 1'b0;
    int   requested, returned, written, max_occ, stab_err;

    logic        rd_pend;
    logic [31:0] rd_pend_addr;
    logic [6:0]  rd_pend_bc;
    logic        in_wr;
    logic [31:0] wr_cap_addr;
    int          wr_cap_bc;
    int          wr_beat;

    function automatic logic [15:0] pat(input logic [31:0] a);
        return a[16:1] ^ a[31:16] ^ 16'hC35A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural slaves: decide handshakes mid-cycle for the next rising edge.
    initial begin
        rd_waitrequest   = 1'b1;
        rd_readdatavalid = 1'b0;
        rd_readdata      = '0;
        wr_waitrequest   = 1'b1;
        rd_pend = 1'b0;
        in_wr   = 1'b0;
        wr_beat = 0;
        forever begin
            @(negedge clk);
            if (rd_beat_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                rd_readdatavalid = 1'b1;
                rd_readdata      = pat(rd_beat_q.pop_front());
                returned++;
            end else begin
                rd_readdatavalid = 1'b0;
            end

            if (reset_n && rd_read) begin
                if (rd_pend && (rd_address !== rd_pend_addr || rd_burstcount !== rd_pend_bc))
                    stab_err++;
                rd_waitrequest = ($urandom_range(99) < rd_wait_pct);
                if (!rd_waitrequest) begin
                    rd_log.push_back('{rd_address, int'(rd_burstcount)});
                    for (int i = 0; i < int'(rd_burstcount); i++)
                        rd_beat_q.push_back(rd_address + 32'(2 * i));
                    requested += int'(rd_burstcount);
                    rd_pend = 1'b0;
                end else begin
                    rd_pend      = 1'b1;
                    rd_pend_addr = rd_address;
                    rd_pend_bc   = rd_burstcount;
                end
            end else begin
                if (rd_pend && reset_n) stab_err++;
                rd_pend        = 1'b0;
                rd_waitrequest = ($urandom_range(99) < rd_wait_pct);
            end

            if (!reset_n) begin
                in_wr   = 1'b0;
                wr_beat = 0;
            end
            if (wr_write) begin
                if (!in_wr) begin
                    in_wr       = 1'b1;
                    wr_cap_addr = wr_address;
                    wr_cap_bc   = int'(wr_burstcount);
                    wr_beat     = 0;
                    wr_log.push_back('{wr_address, int'(wr_burstcount)});
                end else if (wr_address !== wr_cap_addr || int'(wr_burstcount) != wr_cap_bc) begin
                    stab_err++;
                end
                wr_waitrequest = wr_hold || ($urandom_range(99) < wr_wait_pct);
                if (!wr_waitrequest) begin
                    dst_mem[wr_cap_addr + 32'(2 * wr_beat)] = wr_writedata;
                    wr_beat++;
                    written++;
                    if (wr_beat == wr_cap_bc) in_wr = 1'b0;
                end
            end else begin
                if (in_wr && reset_n) stab_err++;
                in_wr          = 1'b0;
                wr_waitrequest = wr_hold || ($urandom_range(99) < wr_wait_pct);
            end
            if (requested - written > max_occ) max_occ = requested - written;
        end
    end

    task automatic run_case(input string tag, input vec_t v);
        int          bad;
        int          cyc;
        int          ebc;
        logic [31:0] sa;
        logic [31:0] da;
        burst_t      last;
        @(negedge clk);
        #1;
        rd_wait_pct = v.rd_pct;
        wr_wait_pct = v.wr_pct;
        gap_pct     = v.gap_pct;
        wr_hold     = (v.hold_cyc > 0);
        dst_mem.delete();
        rd_log.delete();
        wr_log.delete();
        requested = 0; returned = 0; written = 0; max_occ = 0; stab_err = 0;
        src_addr  = v.src;
        dst_addr  = v.dst;
        len_words = 24'(v.len);
        start     = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        check({tag, "_start_busy"}, 64'(busy), 64'd1);
        check({tag, "_start_done_clr"}, 64'(done), 64'd0);

        for (cyc = 0; cyc < v.budget && done !== 1'b1; cyc++) begin
            @(negedge clk);
            #1;
            if (v.restart_at > 0 && cyc == v.restart_at) begin
                start     = 1'b1;
                len_words = 24'd5;
                src_addr  = 32'hDEAD0;
            end
            if (v.restart_at > 0 && cyc == v.restart_at + 1) start = 1'b0;
            if (v.hold_cyc > 0 && cyc == v.hold_cyc) begin
                check({tag, "_hold_requested"}, 64'(requested), 64'd32);
                check({tag, "_hold_wr_write"}, 64'(wr_write), 64'd1);
                wr_hold = 1'b0;
            end
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_status"}, 64'(status), 64'(v.exp_status));
        check({tag, "_rd_bursts"}, 64'(rd_log.size()), 64'(v.exp_bursts));
        check({tag, "_wr_bursts"}, 64'(wr_log.size()), 64'(v.exp_bursts));

        bad = 0;
        for (int i = 0; i < rd_log.size(); i++) begin
            ebc = (v.len - 8 * i < 8) ? v.len - 8 * i : 8;
            if (rd_log[i].addr !== v.src + 32'(16 * i) || rd_log[i].bc != ebc) bad++;
        end
        for (int i = 0; i < wr_log.size(); i++) begin
            ebc = (v.len - 8 * i < 8) ? v.len - 8 * i : 8;
            if (wr_log[i].addr !== v.dst + 32'(16 * i) || wr_log[i].bc != ebc) bad++;
        end
        check({tag, "_burst_shape_errs"}, 64'(bad), 64'd0);

        last = (wr_log.size() > 0) ? wr_log[wr_log.size() - 1] : '{32'd0, 0};
        check({tag, "_last_wr_addr"}, 64'(last.addr), 64'(v.exp_last_wr));
        check({tag, "_last_wr_bc"}, 64'(last.bc), 64'(v.exp_last_bc));

        bad = 0;
        for (int i = 0; i < v.len; i++) begin
            sa = v.src + 32'(2 * i);
            da = v.dst + 32'(2 * i);
            if (!dst_mem.exists(da) || dst_mem[da] !== pat(sa)) bad++;
        end
        check({tag, "_data_errs"}, 64'(bad), 64'd0);
        check({tag, "_words_written"}, 64'(written), 64'(v.len));
        check({tag, "_stability_errs"}, 64'(stab_err), 64'd0);
        check({tag, "_occupancy_le_32"}, 64'(max_occ <= 32), 64'd1);

        repeat (3) @(negedge clk);
        #1;
        check({tag, "_done_holds"}, 64'(done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({busy, done, status, rd_read, wr_write, rd_burstcount, wr_burstcount}), 64'd0);
        check({tag, "_addr"}, {rd_address, wr_address}, 64'd0);
        check({tag, "_wdata"}, 64'(wr_writedata), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int activity;
        int k;
        //            len  src            dst            rd  wr  gap rst hold budget bursts st    last_wr        bc
        vecs[0] = '{8,    32'h0000_1000, 32'h0000_2000, 0,  0,  0,  0,  0,   200,   1,     4'd1,  32'h0000_2000, 8};
        vecs[1] = '{21,   32'h0000_1000, 32'h0000_2000, 0,  0,  0,  0,  0,   300,   3,     4'd3,  32'h0000_2020, 5};
        vecs[2] = '{1000, 32'h0001_0000, 32'h0008_0000, 30, 30, 30, 0,  0,   20000, 125,   4'd13, 32'h0008_07C0, 8};
        vecs[3] = '{1,    32'h0000_1234, 32'h0000_5678, 0,  0,  0,  0,  0,   100,   1,     4'd1,  32'h0000_5678, 1};
        vecs[4] = '{12,   32'hFFFF_FFF8, 32'hFFFF_FFF0, 0,  0,  0,  0,  0,   200,   2,     4'd2,  32'h0000_0000, 4};
        vecs[5] = '{130,  32'h0000_4000, 32'h0000_6000, 20, 20, 20, 0,  0,   3000,  17,    4'd1,  32'h0000_6100, 2};
        vecs[6] = '{40,   32'h0000_0100, 32'h0000_0900, 10, 10, 10, 6,  0,   1000,  5,     4'd5,  32'h0000_0940, 8};
        vecs[7] = '{100,  32'h0000_2000, 32'h0000_3000, 0,  0,  0,  0,  150, 2000,  13,    4'd13, 32'h0000_30C0, 4};
        vecs[8] = '{4,    32'h0000_0500, 32'h0000_0700, 0,  0,  0,  0,  0,   200,   1,     4'd1,  32'h0000_0700, 4};

        reset_n   = 1'b0;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len_words = '0;
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("reset");

        start     = 1'b1;
        len_words = 24'd0;
        @(negedge clk);
        #1;
        start = 1'b0;
        check("zero_len_done", 64'(done), 64'd1);
        check("zero_len_busy", 64'(busy), 64'd0);
        activity = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (busy || rd_read || wr_write) activity++;
        end
        check("zero_len_no_activity", 64'(activity), 64'd0);
        check("zero_len_done_holds", 64'(done), 64'd1);

        for (int i = 0; i < 8; i++) run_case($sformatf("vec%0d", i), vecs[i]);

        // Abort a transfer mid-burst while read beats are still in flight.
        rd_wait_pct = 0;
        wr_wait_pct = 50;
        gap_pct     = 60;
        wr_hold     = 1'b0;
        @(negedge clk);
        #1;
        src_addr  = 32'h0000_3000;
        dst_addr  = 32'h0000_4000;
        len_words = 24'd64;
        start     = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        for (k = 0; k < 400 && !(wr_write === 1'b1 && rd_beat_q.size() > 0); k++) begin
            @(negedge clk);
            #1;
        end
        check("abort_mid_burst_reached", 64'(wr_write === 1'b1 && rd_beat_q.size() > 0), 64'd1);
        gap_pct = 100;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("abort_async");
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        gap_pct = 30;
        for (k = 0; k < 500 && rd_beat_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        check("abort_stale_drained", 64'(rd_beat_q.size()), 64'd0);
        repeat (4) @(negedge clk);
        #1;
        check_all_zero("abort_idle");
        run_case("after_abort", vecs[8]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_burst_mover.md
Name: sdram_burst_mover

Overview:
- Parametrised start/done copy engine between two Avalon-MM burst ports: one read master on the source SDRAM window, one write master on the destination window.
- Replaces the single-signal SDRAM start/stop hook used by the edge-detection accelerator. Adds configurable data width, burst length, transfer length and an internal decoupling FIFO.
- Driven by HPS PIOs: start, addresses and length come in; done, busy and status go out, with the status nibble feeding the HEX display.

Parameters:
DATA_W, 16, data bus width in bits; byte address step is DATA_W/8.
ADDR_W, 32, byte address width of both masters.
LEN_W, 24, width of the transfer length in words.
BURST_LEN, 8, maximum beats per burst, power of two, 1..64.
BC_W, 7, burstcount width; must hold BURST_LEN.
FIFO_DEPTH, 32, FIFO words, power of two, at least 2*BURST_LEN.

Ports:
clk  in  1  system clock, all logic rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  rising-edge-detected request from PIO
src_addr  in  ADDR_W  source byte address, sampled at start
dst_addr  in  ADDR_W  destination byte address, sampled at start
len_words  in  LEN_W  words to copy, sampled at start
busy  out  1  transfer in progress
done  out  1  transfer complete, level
status  out  4  low 4 bits of completed write-burst count
rd_address  out  ADDR_W  read master address
rd_read  out  1  read request
rd_burstcount  out  BC_W  read burst length
rd_waitrequest  in  1  slave stall
rd_readdata  in  DATA_W  returned data
rd_readdatavalid  in  1  returned data valid
wr_address  out  ADDR_W  write master address
wr_write  out  1  write request
wr_burstcount  out  BC_W  write burst length
wr_writedata  out  DATA_W  write data
wr_waitrequest  in  1  slave stall

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, all counters 0, both FSMs in IDLE.
- Start detect:
  - start is registered; a 0->1 edge while busy=0 latches src_addr, dst_addr and len_words.
  - Sets busy=1 and clears done and the burst counter on the next cycle.
  - Edges while busy=1 are ignored.
- Zero length: if len_words==0, busy stays 0 and done=1 one cycle after the edge.
- Read FSM (R_IDLE, R_REQ, R_WAIT):
  - In R_IDLE, issue a burst when words_left_rd>0 and FIFO_DEPTH - fifo_count - outstanding >= n, where n = min(BURST_LEN, words_left_rd).
  - R_REQ holds rd_read=1 with rd_address and rd_burstcount=n stable until rd_waitrequest=0.
  - On acceptance: outstanding += n, rd_address += n*DATA_W/8, words_left_rd -= n, return to R_IDLE.
  - Multiple bursts may be outstanding.
- Each rd_readdatavalid beat pushes rd_readdata into the FIFO and decrements outstanding. The FIFO never overflows by construction; an overflow is an assertion failure.
- Write FSM (W_IDLE, W_BURST):
  - Start a burst when fifo_count >= m, where m = min(BURST_LEN, words_left_wr).
  - In W_BURST, wr_write=1, wr_address and wr_burstcount=m are held constant for the whole burst, and wr_writedata = FIFO head.
  - A beat completes when wr_write=1 and wr_waitrequest=0; the FIFO pops on that beat.
  - After beat m: wr_address += m*DATA_W/8, words_left_wr -= m, burst counter +1, go to W_IDLE.
  - wr_write is never deasserted mid-burst.
- Completion: when words_left_wr reaches 0 after the final beat, busy=0 and done=1 on the next cycle. done holds until the next accepted start edge.
- FIFO: first-word-fall-through. A push and a pop in the same cycle leave the count unchanged.
- Final bursts: a partial read burst and a partial write burst both use the remainder length.
- Addresses wrap modulo 2^ADDR_W; no error is flagged.
- status = burst counter [3:0], wrapping 15->0.
- Reset mid-operation aborts immediately. Any in-flight read data arriving after reset release is dropped, because outstanding has been cleared to 0.

Test Plan:
1. Reset then idle -> all outputs 0. Pulse start with len=0 -> done=1 one cycle later, busy never 1, no rd_read/wr_write.
2. len=8, src=0x1000, dst=0x2000, zero-wait slaves -> one read burst at 0x1000 with burstcount 8, one write burst at 0x2000 with burstcount 8, data matches, status=1, done=1.
3. len=21, BURST_LEN=8 -> read and write bursts of 8, 8 and 5; write addresses 0x2000, 0x2010, 0x2020; status=3.
4. Random rd_waitrequest, wr_waitrequest and readdatavalid gaps, len=1000 -> byte-exact copy; wr_address/burstcount stable during stalls; FIFO never over 32.
5. Second start edge mid-transfer -> ignored, latched length unchanged. Assert reset_n low mid-burst -> outputs 0 asynchronously; after release, a new len=4 transfer completes correctly.
6. Write slave stalled solid -> reads stop issuing once FIFO plus outstanding equals 32; on release all data drains and done=1.
